// File: rtl/execute_stage_pkg.sv
// Shared opcode encodings, datapath defaults and EX FSM state type.
package execute_stage_pkg;

  localparam int unsigned DataWDefault = 32;
  localparam int unsigned RegAwDefault = 5;

  localparam logic [5:0] OpAdd = 6'b000000;
  localparam logic [5:0] OpSub = 6'b000001;
  localparam logic [5:0] OpAnd = 6'b000010;
  localparam logic [5:0] OpOr  = 6'b000011;
  localparam logic [5:0] OpXor = 6'b000100;
  localparam logic [5:0] OpSlt = 6'b000101;
  localparam logic [5:0] OpMul = 6'b000110;
  localparam logic [5:0] OpLw  = 6'b010000;
  localparam logic [5:0] OpSw  = 6'b010001;
  localparam logic [5:0] OpBeq = 6'b100000;
  localparam logic [5:0] OpJmp = 6'b100001;

  typedef enum logic [0:0] {
    StIdle,
    StMulBusy
  } ex_state_e;

endpackage

// File: rtl/execute_stage_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low W bits of the product.
module mul_seq #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int unsigned CntW = $clog2(W);

  logic [W-1:0]    a_q, b_q, acc_q, acc_next;
  logic [CntW-1:0] cnt_q;
  logic            busy_q;

  assign acc_next = a_q[0] ? acc_q + b_q : acc_q;
  // done is asserted during the last iteration; product already includes that step.
  assign done     = busy_q && (cnt_q == CntW'(W - 1));
  assign product  = acc_next;
  assign busy     = busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      a_q    <= a;
      b_q    <= b;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_next;
      a_q   <= a_q >> 1;
      b_q   <= b_q << 1;
      cnt_q <= cnt_q + CntW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// EX pipeline stage: combinational ALU/branch unit, sequenced multiplier, one output register.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned REG_AW = RegAwDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        op_ex,
  input  logic [DATA_W-1:0] A_ex,
  input  logic [DATA_W-1:0] B_ex,
  input  logic [DATA_W-1:0] Imm_ex,
  input  logic [DATA_W-1:0] npc_ex,
  input  logic [REG_AW-1:0] Ri_ex,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        op_mem,
  output logic [DATA_W-1:0] alu_out_mem,
  output logic [DATA_W-1:0] B_mem,
  output logic [REG_AW-1:0] Ri_mem,
  output logic              wb_en_mem,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target
);

  ex_state_e state_q, state_d;

  logic              accept, is_mul, mul_busy, mul_done;
  logic [DATA_W-1:0] mul_product, mul_b_q;
  logic [REG_AW-1:0] mul_ri_q;

  logic              load_c, wb_c, taken_c;
  logic [DATA_W-1:0] alu_c, bdata_c, imm_sext, beq_tgt, jmp_tgt;

  logic              out_valid_q, wb_q, br_taken_q;
  logic [5:0]        op_q;
  logic [DATA_W-1:0] alu_q, b_q, br_target_q;
  logic [REG_AW-1:0] ri_q;

  logic unused_imm;
  assign unused_imm = ^Imm_ex[DATA_W-1:26];

  assign in_ready = (state_q == StIdle) & ~mul_busy & (~out_valid_q | out_ready) & rst_n;
  assign accept   = in_valid & in_ready;
  assign is_mul   = (op_ex == OpMul);

  assign imm_sext = {{(DATA_W - 16){Imm_ex[15]}}, Imm_ex[15:0]};
  assign beq_tgt  = npc_ex + (imm_sext << 2);
  assign jmp_tgt  = {npc_ex[DATA_W-1:28], Imm_ex[25:0], 2'b00};

  always_comb begin
    alu_c   = '0;
    bdata_c = B_ex;
    wb_c    = 1'b1;
    load_c  = 1'b1;
    taken_c = 1'b0;
    case (op_ex)
      OpAdd: alu_c = A_ex + B_ex;
      OpSub: alu_c = A_ex - B_ex;
      OpAnd: alu_c = A_ex & B_ex;
      OpOr:  alu_c = A_ex | B_ex;
      OpXor: alu_c = A_ex ^ B_ex;
      OpSlt: alu_c = {{(DATA_W - 1){1'b0}}, $signed(A_ex) < $signed(B_ex)};
      OpLw: begin
        alu_c   = B_ex + imm_sext;
        bdata_c = A_ex;
      end
      OpSw: begin
        alu_c   = B_ex + imm_sext;
        bdata_c = A_ex;
        wb_c    = 1'b0;
      end
      OpBeq: begin
        alu_c   = beq_tgt;
        wb_c    = 1'b0;
        taken_c = (A_ex == B_ex);
      end
      OpJmp: begin
        alu_c   = jmp_tgt;
        wb_c    = 1'b0;
        taken_c = 1'b1;
      end
      // MUL is loaded by the sequencer when it finishes; everything else is a NOP.
      default: begin
        wb_c   = 1'b0;
        load_c = 1'b0;
      end
    endcase
  end

  mul_seq #(
    .W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept & is_mul),
    .a       (A_ex),
    .b       (B_ex),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (accept && is_mul) state_d = StMulBusy;
      StMulBusy: if (mul_done) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      op_q        <= '0;
      alu_q       <= '0;
      b_q         <= '0;
      ri_q        <= '0;
      wb_q        <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      mul_b_q     <= '0;
      mul_ri_q    <= '0;
    end else begin
      br_taken_q <= accept & taken_c;
      if (accept && taken_c) br_target_q <= alu_c;
      if (accept && is_mul) begin
        mul_b_q  <= B_ex;
        mul_ri_q <= Ri_ex;
      end
      // The slot drained when the MUL was accepted, so the result lands unconditionally.
      if (mul_done) begin
        out_valid_q <= 1'b1;
        op_q        <= OpMul;
        alu_q       <= mul_product;
        b_q         <= mul_b_q;
        ri_q        <= mul_ri_q;
        wb_q        <= 1'b1;
      end else if (accept && load_c) begin
        out_valid_q <= 1'b1;
        op_q        <= op_ex;
        alu_q       <= alu_c;
        b_q         <= bdata_c;
        ri_q        <= Ri_ex;
        wb_q        <= wb_c;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign op_mem      = op_q;
  assign alu_out_mem = alu_q;
  assign B_mem       = b_q;
  assign Ri_mem      = ri_q;
  assign wb_en_mem   = wb_q;
  assign br_taken    = br_taken_q;
  assign br_target   = br_target_q;

endmodule
